// File: rtl/id_stage_pipelined_if.sv
// Decode-stage bus: IF/ID inputs, side-band hazard/write-back
// inputs and the registered ID/EX outputs.
interface id_stage_pipelined_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       instr_in;
  logic [31:0]       pc_in;
  logic              instr_valid;
  logic              stall_in;
  logic              flush;
  logic [3:0]        sr;
  logic              wb_en_in;
  logic [3:0]        wb_dest;
  logic [DATA_W-1:0] wb_value;
  logic [3:0]        exe_dest;
  logic              exe_wb_en;
  logic [3:0]        mem_dest;
  logic              mem_wb_en;
  logic              hazard_out;
  logic              valid_out;
  logic              wb_en;
  logic              mem_r_en;
  logic              mem_w_en;
  logic              b;
  logic              s;
  logic              imm;
  logic [3:0]        exe_cmd;
  logic [DATA_W-1:0] val_rn;
  logic [DATA_W-1:0] val_rm;
  logic [11:0]       shift_operand;
  logic [23:0]       signed_imm_24;
  logic [3:0]        dest;
  logic [3:0]        src1;
  logic [3:0]        src2;
  logic [31:0]       pc_out;

  modport master (
    output instr_in, pc_in, instr_valid, stall_in, flush, sr,
           wb_en_in, wb_dest, wb_value, exe_dest, exe_wb_en,
           mem_dest, mem_wb_en,
    input  hazard_out, valid_out, wb_en, mem_r_en, mem_w_en,
           b, s, imm, exe_cmd, val_rn, val_rm, shift_operand,
           signed_imm_24, dest, src1, src2, pc_out
  );

  modport slave (
    input  instr_in, pc_in, instr_valid, stall_in, flush, sr,
           wb_en_in, wb_dest, wb_value, exe_dest, exe_wb_en,
           mem_dest, mem_wb_en,
    output hazard_out, valid_out, wb_en, mem_r_en, mem_w_en,
           b, s, imm, exe_cmd, val_rn, val_rm, shift_operand,
           signed_imm_24, dest, src1, src2, pc_out
  );
endinterface

// File: rtl/id_stage_pipelined.sv
// Decode stage: register file, condition check, control decode,
// RAW hazard detect and the ID/EX pipeline register.
module id_stage_pipelined #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 15,
  parameter int WB_BYPASS = 1,
  parameter int HAZARD_EN = 1
) (
  input logic                 clk,
  input logic                 rst,
  id_stage_pipelined_if.slave bus
);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic              b;
    logic              s;
    logic              imm;
    logic [3:0]        exe_cmd;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic [11:0]       shift_operand;
    logic [23:0]       simm24;
    logic [3:0]        dest;
    logic [3:0]        src1;
    logic [3:0]        src2;
    logic [31:0]       pc;
  } id_ex_t;

  logic [DATA_W-1:0] regs_q [16];
  id_ex_t            idex_q, idex_d;

  logic [31:0]       ir;
  logic [1:0]        mode;
  logic [3:0]        opc;
  logic [3:0]        src1_w, src2_w;
  logic              is_str, is_mov;
  logic              cond_ok;
  logic              uses_rn, uses_rm;
  logic              m1, m2, hazard;
  logic [DATA_W-1:0] rn_val, rm_val;
  logic              c_wb, c_mr, c_mw, c_b, c_s, c_imm;
  logic [3:0]        c_cmd;

  assign ir     = bus.instr_in;
  assign mode   = ir[27:26];
  assign opc    = ir[24:21];
  assign is_str = (mode == 2'b01) && !ir[20];
  assign is_mov = (mode == 2'b00) &&
                  ((opc == OP_MOV) || (opc == OP_MVN));
  assign src1_w = ir[19:16];
  assign src2_w = is_str ? ir[15:12] : ir[3:0];

  // Condition field evaluated against NZCV
  always_comb begin
    cond_ok = 1'b0;
    case (ir[31:28])
      4'b0000: cond_ok = bus.sr[2];
      4'b0001: cond_ok = !bus.sr[2];
      4'b0010: cond_ok = bus.sr[1];
      4'b0011: cond_ok = !bus.sr[1];
      4'b0100: cond_ok = bus.sr[3];
      4'b0101: cond_ok = !bus.sr[3];
      4'b0110: cond_ok = bus.sr[0];
      4'b0111: cond_ok = !bus.sr[0];
      4'b1000: cond_ok = bus.sr[1] && !bus.sr[2];
      4'b1001: cond_ok = !bus.sr[1] || bus.sr[2];
      4'b1010: cond_ok = bus.sr[3] == bus.sr[0];
      4'b1011: cond_ok = bus.sr[3] != bus.sr[0];
      4'b1100: cond_ok = !bus.sr[2] &&
                         (bus.sr[3] == bus.sr[0]);
      4'b1101: cond_ok = bus.sr[2] ||
                         (bus.sr[3] != bus.sr[0]);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Control decode by instruction class
  always_comb begin
    c_wb  = 1'b0;
    c_mr  = 1'b0;
    c_mw  = 1'b0;
    c_b   = 1'b0;
    c_s   = 1'b0;
    c_imm = 1'b0;
    c_cmd = 4'b0000;
    unique case (1'b1)
      (mode == 2'b00): begin
        c_s   = ir[20];
        c_imm = ir[25];
        c_wb  = 1'b1;
        case (opc)
          OP_MOV: c_cmd = 4'b0001;
          OP_MVN: c_cmd = 4'b1001;
          OP_ADD: c_cmd = 4'b0010;
          OP_ADC: c_cmd = 4'b0011;
          OP_SUB: c_cmd = 4'b0100;
          OP_SBC: c_cmd = 4'b0101;
          OP_AND: c_cmd = 4'b0110;
          OP_ORR: c_cmd = 4'b0111;
          OP_EOR: c_cmd = 4'b1000;
          OP_CMP: begin
            c_cmd = 4'b0100;
            c_wb  = 1'b0;
          end
          OP_TST: begin
            c_cmd = 4'b0110;
            c_wb  = 1'b0;
          end
          default: begin
            c_s   = 1'b0;
            c_imm = 1'b0;
            c_wb  = 1'b0;
          end
        endcase
      end
      (mode == 2'b01): begin
        c_cmd = 4'b0010;
        c_imm = ir[25];
        c_mr  = ir[20];
        c_wb  = ir[20];
        c_mw  = !ir[20];
      end
      (mode == 2'b10): c_b = 1'b1;
      default: ;
    endcase
  end

  // Operand reads; out-of-range indices have no storage
  always_comb begin
    rn_val = '0;
    rm_val = '0;
    if (int'(src1_w) < NUM_REGS) begin
      rn_val = regs_q[src1_w];
      if ((WB_BYPASS != 0) && bus.wb_en_in &&
          (bus.wb_dest == src1_w))
        rn_val = bus.wb_value;
    end
    if (int'(src2_w) < NUM_REGS) begin
      rm_val = regs_q[src2_w];
      if ((WB_BYPASS != 0) && bus.wb_en_in &&
          (bus.wb_dest == src2_w))
        rm_val = bus.wb_value;
    end
  end

  // RAW check against EX and MEM destinations
  always_comb begin
    uses_rn = bus.instr_valid && (mode != 2'b10) && !is_mov;
    uses_rm = bus.instr_valid &&
              (is_str || ((mode == 2'b00) && !ir[25]));
    m1 = (bus.exe_wb_en && (bus.exe_dest == src1_w)) ||
         (bus.mem_wb_en && (bus.mem_dest == src1_w));
    m2 = (bus.exe_wb_en && (bus.exe_dest == src2_w)) ||
         (bus.mem_wb_en && (bus.mem_dest == src2_w));
    hazard = (HAZARD_EN != 0) &&
             ((uses_rn && m1) || (uses_rm && m2));
  end

  assign bus.hazard_out = hazard;

  // Next ID/EX contents: bubble or decoded bundle
  always_comb begin
    idex_d = '0;
    if (!(bus.flush || hazard || !bus.instr_valid)) begin
      idex_d.val_rn        = rn_val;
      idex_d.val_rm        = rm_val;
      idex_d.shift_operand = ir[11:0];
      idex_d.simm24        = ir[23:0];
      idex_d.dest          = ir[15:12];
      idex_d.src1          = src1_w;
      idex_d.src2          = src2_w;
      idex_d.pc            = bus.pc_in;
      if (cond_ok) begin
        idex_d.valid    = 1'b1;
        idex_d.wb_en    = c_wb;
        idex_d.mem_r_en = c_mr;
        idex_d.mem_w_en = c_mw;
        idex_d.b        = c_b;
        idex_d.s        = c_s;
        idex_d.imm      = c_imm;
        idex_d.exe_cmd  = c_cmd;
      end
    end
  end

  // ID/EX register; a downstream stall freezes it
  always_ff @(posedge clk) begin
    if (rst)
      idex_q <= '0;
    else if (!bus.stall_in)
      idex_q <= idex_d;
  end

  // Register file write port, independent of stall/flush
  always_ff @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (rst)
        regs_q[i] <= '0;
      else if (bus.wb_en_in && (bus.wb_dest == 4'(i)) &&
               (i < NUM_REGS))
        regs_q[i] <= bus.wb_value;
    end
  end

  assign bus.valid_out     = idex_q.valid;
  assign bus.wb_en         = idex_q.wb_en;
  assign bus.mem_r_en      = idex_q.mem_r_en;
  assign bus.mem_w_en      = idex_q.mem_w_en;
  assign bus.b             = idex_q.b;
  assign bus.s             = idex_q.s;
  assign bus.imm           = idex_q.imm;
  assign bus.exe_cmd       = idex_q.exe_cmd;
  assign bus.val_rn        = idex_q.val_rn;
  assign bus.val_rm        = idex_q.val_rm;
  assign bus.shift_operand = idex_q.shift_operand;
  assign bus.signed_imm_24 = idex_q.simm24;
  assign bus.dest          = idex_q.dest;
  assign bus.src1          = idex_q.src1;
  assign bus.src2          = idex_q.src2;
  assign bus.pc_out        = idex_q.pc;
endmodule
